rv32i_io_bridge: RTL and testbench

- Sits directly downstream of the RV32I core's external memory port and services every load/store outside local memory (addr[31:28] != LOCAL_TADDR).
- Holds the core with o_stall while it runs a valid/ready transaction on the peripheral bus.
- Returns load data already lane-aligned and sign/zero-extended per funct3, because the core applies no load formatting to external data.
- Builds byte enables and lane-replicated write data for stores.

---
 rtl/rv32i_io_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_rv32i_io_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_io_bridge.sv
// rv32i_io_bridge
//   Bridges the RV32I core's external memory port to a valid/ready peripheral
//   bus. Every load/store whose address is outside core-local memory is run as
//   a single bus transaction while the core is held with o_stall. Load data is
//   returned lane-aligned and sign/zero-extended. Store data is lane-replicated
//   and given byte enables.
//
// Ports
//   CLK, RST_X           clock, asynchronous active-low reset
//   i_req                core access type (0=RD, 1=WR, 2=IF, 3=none)
//   i_addr, i_wdata      core data address and raw store data (rs2)
//   i_mmuwe              core external-write strobe
//   i_ctrl               funct3 size/sign code
//   o_stall              hold request to the core
//   o_rdata              formatted load data (changes only on completion)
//   o_bus_*              peripheral request: valid, we, word address, be, wdata
//   i_bus_ready          peripheral accept/complete
//   i_bus_rdata          peripheral read word, valid with ready
//   o_err, i_err_clr     sticky error flag (timeout or misaligned) and its clear
module rv32i_io_bridge #(
    parameter logic [3:0]  LOCAL_TADDR = 4'h1,
    parameter int unsigned TMO_BITS    = 8
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [1:0]  i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mmuwe,
    input  logic [2:0]  i_ctrl,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_err,
    input  logic        i_err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [TMO_BITS-1:0] cnt;
    logic [TMO_BITS-1:0] cnt_inc;
    logic [1:0]          off_q;
    logic [2:0]          ctrl_q;

    logic        ext_rd;
    logic        ext_wr;
    logic        access;
    logic        misaligned;
    logic        timeout;
    logic        err_set;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_shift;
    logic [31:0] rd_fmt;

    assign ext_rd  = (i_req == 2'd0) && (i_addr[31:28] != LOCAL_TADDR);
    assign ext_wr  = i_mmuwe;
    assign access  = ext_rd || ext_wr;

    // Half needs addr[0]==0; anything that is not byte or half is a word.
    always_comb begin
        misaligned = 1'b0;
        case (i_ctrl[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_addr[0];
            default: misaligned = (i_addr[1:0] != 2'b00);
        endcase
    end

    // The increment that would land on the all-ones value is the last BUSY cycle.
    assign cnt_inc = cnt + 1'b1;
    assign timeout = &cnt_inc;

    // Combinational so the core holds in EX on the very first cycle.
    assign o_stall = ((state == IDLE) && access) || (state == BUSY);

    assign err_set = ((state == IDLE) && access && misaligned) ||
                     ((state == BUSY) && !i_bus_ready && timeout);

    always_comb begin
        wr_be   = 4'hF;
        wr_data = i_wdata;
        case (i_ctrl[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << i_addr[1:0];
                wr_data = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << {i_addr[1], 1'b0};
                wr_data = {2{i_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'hF;
                wr_data = i_wdata;
            end
        endcase
    end

    assign rd_shift = i_bus_rdata >> {off_q, 3'b000};

    always_comb begin
        rd_fmt = rd_shift;
        case (ctrl_q)
            3'b000:  rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  rd_fmt = {24'h0, rd_shift[7:0]};
            3'b001:  rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  rd_fmt = {16'h0, rd_shift[15:0]};
            default: rd_fmt = rd_shift;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (access) begin
                    state_nx = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (i_bus_ready || timeout) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            o_bus_valid <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
            o_rdata     <= '0;
            cnt         <= '0;
            off_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access) begin
                        if (misaligned) begin
                            o_rdata <= '0;
                        end else begin
                            o_bus_valid <= 1'b1;
                            o_bus_we    <= ext_wr;
                            o_bus_addr  <= {i_addr[31:2], 2'b00};
                            o_bus_be    <= ext_wr ? wr_be : 4'hF;
                            o_bus_wdata <= wr_data;
                            off_q       <= i_addr[1:0];
                            ctrl_q      <= i_ctrl;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_inc;
                    // Ready on the limit cycle is still a normal completion.
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        if (!o_bus_we) begin
                            o_rdata <= rd_fmt;
                        end
                    end else if (timeout) begin
                        o_bus_valid <= 1'b0;
                        o_rdata     <= 32'hFFFF_FFFF;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_io_bridge.sv
// tb_rv32i_io_bridge
//   Directed bench for rv32i_io_bridge (TMO_BITS=4). Each access pushes its
//   expected result onto a scoreboard queue when driven; the entry is popped
//   and compared when the bridge releases the stall.
module tb_rv32i_io_bridge;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [1:0]  i_req = 2'd3;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_mmuwe = 1'b0;
    logic [2:0]  i_ctrl = '0;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_bus_valid;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_err;
    logic        i_err_clr = 1'b0;

    rv32i_io_bridge #(.LOCAL_TADDR(4'h1), .TMO_BITS(4)) dut (
        .CLK(CLK), .RST_X(RST_X), .i_req(i_req), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_mmuwe(i_mmuwe), .i_ctrl(i_ctrl),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_bus_valid(o_bus_valid),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready),
        .i_bus_rdata(i_bus_rdata), .o_err(o_err), .i_err_clr(i_err_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          valids;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one core access, act as a slave with `waits` wait cycles, and
    // score the result when the stall releases.
    task automatic access(input string tag, input logic [1:0] req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] ctrl, input int waits,
                          input logic [31:0] brdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_stalls,
                          input int exp_valids);
        exp_t e;
        int   st;
        int   vl;
        bit   moved;
        @(negedge CLK);
        i_req   = req;
        i_mmuwe = we;
        i_addr  = addr;
        i_wdata = wdata;
        i_ctrl  = ctrl;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.stalls = exp_stalls;
        e.valids = exp_valids;
        sb.push_back(e);
        st = 0;
        vl = 0;
        moved = 1'b0;
        for (int n = 0; n < 64; n++) begin
            #1;
            if (!o_stall) break;
            st++;
            if (o_bus_valid) begin
                if (vl == 0) begin
                    cap_addr  = o_bus_addr;
                    cap_wdata = o_bus_wdata;
                    cap_be    = o_bus_be;
                    cap_we    = o_bus_we;
                end else if (o_bus_addr !== cap_addr || o_bus_wdata !== cap_wdata ||
                             o_bus_be !== cap_be || o_bus_we !== cap_we) begin
                    moved = 1'b1;
                end
                vl++;
                i_bus_ready = (vl > waits);
                i_bus_rdata = brdata;
            end
            @(negedge CLK);
            i_bus_ready = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, " rdata"}, o_rdata, e.rdata);
        chk({tag, " err"}, {31'b0, o_err}, {31'b0, e.err});
        chk({tag, " stall_cycles"}, 32'(st), 32'(e.stalls));
        chk({tag, " valid_cycles"}, 32'(vl), 32'(e.valids));
        chk({tag, " payload_stable"}, {31'b0, moved}, 32'd0);
        chk({tag, " done_valid"}, {31'b0, o_bus_valid}, 32'd0);
        @(negedge CLK);
        i_req   = 2'd3;
        i_mmuwe = 1'b0;
        #1;
        chk({tag, " idle_stall"}, {31'b0, o_stall}, 32'd0);
        chk({tag, " rdata_held"}, o_rdata, e.rdata);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        i_err_clr = 1'b1;
        @(negedge CLK);
        i_err_clr = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        chk("rst valid", {31'b0, o_bus_valid}, 32'd0);
        chk("rst we", {31'b0, o_bus_we}, 32'd0);
        chk("rst addr", o_bus_addr, 32'd0);
        chk("rst be", {28'b0, o_bus_be}, 32'd0);
        chk("rst wdata", o_bus_wdata, 32'd0);
        chk("rst rdata", o_rdata, 32'd0);
        chk("rst err", {31'b0, o_err}, 32'd0);
        chk("rst stall", {31'b0, o_stall}, 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;

        access("rd_half_s", 2'd0, 1'b0, 32'h2000_0006, 32'h0, 3'b001, 0,
               32'h8001_1234, 32'hFFFF_8001, 1'b0, 2, 1);
        chk("rd_half_s addr", cap_addr, 32'h2000_0004);
        chk("rd_half_s be", {28'b0, cap_be}, 32'hF);
        chk("rd_half_s we", {31'b0, cap_we}, 32'd0);

        access("wr_byte", 2'd1, 1'b1, 32'h3000_0003, 32'h0000_00A5, 3'b000, 3,
               32'hDEAD_DEAD, 32'hFFFF_8001, 1'b0, 5, 4);
        chk("wr_byte addr", cap_addr, 32'h3000_0000);
        chk("wr_byte be", {28'b0, cap_be}, 32'h8);
        chk("wr_byte wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("wr_byte we", {31'b0, cap_we}, 32'd1);

        access("local_rd", 2'd0, 1'b0, 32'h1000_0010, 32'h0, 3'b010, 0,
               32'h0, 32'hFFFF_8001, 1'b0, 0, 0);
        access("if_req", 2'd2, 1'b0, 32'h2000_0000, 32'h0, 3'b010, 0,
               32'h0, 32'hFFFF_8001, 1'b0, 0, 0);

        access("wr_half", 2'd1, 1'b1, 32'h3000_0002, 32'h1234_BEEF, 3'b001, 0,
               32'h0, 32'hFFFF_8001, 1'b0, 2, 1);
        chk("wr_half be", {28'b0, cap_be}, 32'hC);
        chk("wr_half wdata", cap_wdata, 32'hBEEF_BEEF);

        access("wr_word", 2'd1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 3'b010, 1,
               32'h0, 32'hFFFF_8001, 1'b0, 3, 2);
        chk("wr_word be", {28'b0, cap_be}, 32'hF);
        chk("wr_word wdata", cap_wdata, 32'hDEAD_BEEF);

        access("rd_byte_s", 2'd0, 1'b0, 32'h4000_0005, 32'h0, 3'b000, 1,
               32'h0000_F000, 32'hFFFF_FFF0, 1'b0, 3, 2);

        access("timeout", 2'd0, 1'b0, 32'h2000_0000, 32'h0, 3'b010, 1000,
               32'h0, 32'hFFFF_FFFF, 1'b1, 16, 15);
        repeat (3) @(negedge CLK);
        #1;
        chk("timeout err_sticky", {31'b0, o_err}, 32'd1);
        pulse_clr();
        chk("timeout err_clr", {31'b0, o_err}, 32'd0);

        access("ready_at_limit", 2'd0, 1'b0, 32'h2000_0000, 32'h0, 3'b010, 14,
               32'h1234_5678, 32'h1234_5678, 1'b0, 16, 15);

        access("misalign_word", 2'd0, 1'b0, 32'h2000_0002, 32'h0, 3'b010, 0,
               32'h0, 32'h0, 1'b1, 1, 0);
        pulse_clr();
        chk("misalign_word clr", {31'b0, o_err}, 32'd0);

        // Clear held high across the setting edge: the set must win.
        i_err_clr = 1'b1;
        access("misalign_half_clr", 2'd0, 1'b0, 32'h2000_0001, 32'h0, 3'b101, 0,
               32'h0, 32'h0, 1'b1, 1, 0);
        i_err_clr = 1'b0;
        #1;
        chk("misalign_half_clr after", {31'b0, o_err}, 32'd0);

        // Reset asserted in the second BUSY cycle.
        @(negedge CLK);
        i_req  = 2'd0;
        i_addr = 32'h2000_0008;
        i_ctrl = 3'b010;
        @(negedge CLK);
        #1;
        chk("rst_mid busy1 valid", {31'b0, o_bus_valid}, 32'd1);
        @(negedge CLK);
        RST_X = 1'b0;
        #1;
        chk("rst_mid valid", {31'b0, o_bus_valid}, 32'd0);
        chk("rst_mid rdata", o_rdata, 32'd0);
        i_req = 2'd3;
        #1;
        chk("rst_mid stall", {31'b0, o_stall}, 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;

        access("post_rst_byte_u", 2'd0, 1'b0, 32'h2000_0007, 32'h0, 3'b100, 0,
               32'hAB00_0000, 32'h0000_00AB, 1'b0, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
